// File: rtl/burst_mon_pkg.sv
// Shared types and helpers for the burst handshake monitor.
// Holds channel state and error enums plus the saturating adder.
package burst_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_M,
    RUN,
    DRAIN
  } ch_state_e;

  // Bit positions of the per-channel error vector.
  typedef enum logic [1:0] {
    ERR_GRANT,
    ERR_HOLD,
    ERR_WINDOW
  } err_type_e;

  localparam int ERR_N = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] lim
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

endpackage

// File: rtl/burst_ch_fsm.sv
// One channel of the burst monitor: FSM, window counters, pulse regs.
// Optional grant-latency tracking under BURST_MON_LAT_EN.
module burst_ch_fsm
  import burst_mon_pkg::*;
#(
  parameter int GRANT_MAX = 4,
  parameter int FREE_LEN  = 6,
  parameter int SLAVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             burst_enable,
  input  logic             master_busy,
  input  logic             slave_busy,
`ifdef BURST_MON_LAT_EN
  input  logic             clear,
  output logic [3:0]       max_lat,
`endif
  output logic             burst_ok,
  output logic [ERR_N-1:0] err
);

  localparam int MX = max3(GRANT_MAX, SLAVE_MAX, FREE_LEN);
  localparam int CW = $clog2(MX + 1);

  ch_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    run_q, run_d;
  logic             en_q;
  logic             ok_q, ok_d;
  logic [ERR_N-1:0] err_q, err_d;
  logic             both_free;

  assign both_free = ~master_busy & ~slave_busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    ok_d    = 1'b0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (burst_enable && !en_q) begin
          state_d = WAIT_M;
          cnt_d   = '0;
        end
      end
      WAIT_M: begin
        if (!burst_enable) begin
          err_d[ERR_HOLD] = 1'b1;
          state_d         = IDLE;
        end else if (!master_busy) begin
          state_d = RUN;
          cnt_d   = '0;
          run_d   = '0;
        end else if (cnt_q == CW'(GRANT_MAX)) begin
          err_d[ERR_GRANT] = 1'b1;
          state_d          = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // cnt_q tracks edges since master-ready while no run has begun
        if (!burst_enable) begin
          err_d[ERR_HOLD] = 1'b1;
          state_d         = IDLE;
        end else if (both_free) begin
          run_d = run_q + 1'b1;
          if (run_d == CW'(FREE_LEN)) begin
            ok_d    = 1'b1;
            state_d = DRAIN;
          end
        end else if (run_q != '0 || cnt_q == CW'(SLAVE_MAX - 1)) begin
          err_d[ERR_WINDOW] = 1'b1;
          state_d           = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!burst_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
      en_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      en_q    <= burst_enable;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign burst_ok = ok_q;
  assign err      = err_q;

`ifdef BURST_MON_LAT_EN
  logic [3:0]  lat_q, lat_d;
  logic [31:0] cnt_w;
  logic [3:0]  lat_new;
  logic        run_entry;

  assign cnt_w     = 32'(cnt_q);
  assign lat_new   = (cnt_w > 32'd15) ? 4'hF : cnt_w[3:0];
  assign run_entry = (state_q == WAIT_M) && burst_enable && !master_busy;

  always_comb begin
    lat_d = lat_q;
    if (clear) lat_d = '0;
    else if (run_entry && lat_new > lat_q) lat_d = lat_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_q <= '0;
    else        lat_q <= lat_d;
  end

  assign max_lat = lat_q;
`endif

endmodule

// File: rtl/burst_protocol_monitor.sv
// Multi-channel burst handshake monitor with sticky flags and count.
// Define BURST_MON_LAT_EN to add the max_grant_lat output.
module burst_protocol_monitor
  import burst_mon_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int GRANT_MAX = 4,
  parameter int FREE_LEN  = 6,
  parameter int SLAVE_MAX = 8,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   burst_enable,
  input  logic [NUM_CH-1:0]   master_busy,
  input  logic [NUM_CH-1:0]   slave_busy,
  input  logic                clear,
`ifdef BURST_MON_LAT_EN
  output logic [NUM_CH*4-1:0] max_grant_lat,
`endif
  output logic [NUM_CH-1:0]   burst_ok,
  output logic [NUM_CH-1:0]   err_grant,
  output logic [NUM_CH-1:0]   err_hold,
  output logic [NUM_CH-1:0]   err_window,
  output logic [NUM_CH-1:0]   err_sticky,
  output logic [CNT_W-1:0]    viol_count
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic [ERR_N-1:0]  err_w [NUM_CH];
  logic [NUM_CH-1:0] errs;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    burst_ch_fsm #(
      .GRANT_MAX (GRANT_MAX),
      .FREE_LEN  (FREE_LEN),
      .SLAVE_MAX (SLAVE_MAX)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .burst_enable (burst_enable[i]),
      .master_busy  (master_busy[i]),
      .slave_busy   (slave_busy[i]),
`ifdef BURST_MON_LAT_EN
      .clear        (clear),
      .max_lat      (max_grant_lat[i*4 +: 4]),
`endif
      .burst_ok     (burst_ok[i]),
      .err          (err_w[i])
    );
    assign err_grant[i]  = err_w[i][ERR_GRANT];
    assign err_hold[i]   = err_w[i][ERR_HOLD];
    assign err_window[i] = err_w[i][ERR_WINDOW];
  end

  assign errs = err_grant | err_hold | err_window;

  // Accounting follows the visible pulses, so clear in the same cycle wins.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + 32'(errs[i]);
    sticky_d = clear ? '0 : (sticky_q | errs);
    cnt_d    = clear ? '0 : CNT_W'(sat_add(32'(cnt_q), pop, CNT_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign err_sticky = sticky_q;
  assign viol_count = cnt_q;

endmodule
